// File: rtl/data_mem_unit.sv
// Multi-cycle data-memory responder with programmable wait states.
// Optional byte write enables: define DMEM_BYTE_STROBE_EN.
module data_mem_unit #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemR,
    input  logic                MemW,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB = DATA_W / 8;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t state;
    state_t nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [3:0]        cnt;
    logic              op_wr;
    logic              bad;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] wd_q;
`ifdef DMEM_BYTE_STROBE_EN
    logic [NB-1:0]     be_q;
`endif

    logic        req;
    logic [31:0] word;
    logic        illegal;

    assign req     = MemR | MemW;
    assign word    = {2'b00, addr[31:2]};
    assign illegal = (addr[1:0] != 2'b00)
                   | (word >= 32'(DEPTH))
                   | (MemR & MemW);

    // Next-state decode; legality decides between waiting and rejecting.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    if (illegal)
                        nxt = S_DONE;
                    else if (WC == 4'd0)
                        nxt = S_ACCESS;
                    else
                        nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1)
                    nxt = S_ACCESS;
            end
            S_ACCESS: nxt = S_DONE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // State register, operand latch, wait counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_wr <= 1'b0;
            bad   <= 1'b0;
            idx_q <= '0;
            wd_q  <= '0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q  <= '0;
`endif
            rdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            busy  <= (nxt == S_WAIT) || (nxt == S_ACCESS);
            done  <= (state == S_DONE);
            err   <= (state == S_DONE) && bad;
            if (state == S_IDLE && req) begin
                cnt   <= WC;
                op_wr <= MemW;
                bad   <= illegal;
                idx_q <= addr[IW+1:2];
                wd_q  <= wdata;
`ifdef DMEM_BYTE_STROBE_EN
                be_q  <= be;
`endif
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == S_ACCESS && !op_wr)
                rdata <= mem[idx_q];
        end
    end

    // Storage array; a reset arriving mid-request suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state == S_ACCESS && op_wr) begin
`ifdef DMEM_BYTE_STROBE_EN
            for (int i = 0; i < NB; i++) begin
                if (be_q[i])
                    mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
            end
`else
            mem[idx_q] <= wd_q;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit (WAIT_CYCLES=2).
// Byte-strobe steps run when DMEM_BYTE_STROBE_EN is defined.
module tb_data_mem_unit;

    logic        clk;
    logic        rst;
    logic        MemR;
    logic        MemW;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  be;
`endif
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int fails  = 0;

    data_mem_unit #(
        .DATA_W(32),
        .DEPTH(256),
        .WAIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MemR(MemR),
        .MemW(MemW),
        .addr(addr),
        .wdata(wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .be(be),
`endif
        .rdata(rdata),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request and waits (bounded) for done.
    // lat = number of rising edges from request until done is seen.
    task automatic do_op(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit tog, output int lat,
                         output logic e, output logic b1);
        MemR = r;
        MemW = w;
        addr = a;
        wdata = d;
        lat = -1;
        e = 1'bx;
        b1 = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                b1 = busy;
                if (tog) begin
                    addr = a ^ 32'h30;
                    wdata = ~d;
                end
            end
            if (done) begin
                lat = k;
                e = err;
                break;
            end
        end
        MemR = 1'b0;
        MemW = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        logic e;
        logic b1;

        rst = 1'b1;
        MemR = 1'b0;
        MemW = 1'b0;
        addr = '0;
        wdata = '0;
`ifdef DMEM_BYTE_STROBE_EN
        be = 4'hF;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Store/load round trip
        do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, e, b1);
        chk("st10_lat", 32'(lat), 32'd5);
        chk("st10_err", {31'b0, e}, 32'h0);
        chk("st10_busy", {31'b0, b1}, 32'h1);
        do_op(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, lat, e, b1);
        chk("st00_err", {31'b0, e}, 32'h0);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, e, b1);
        chk("ld10_lat", 32'(lat), 32'd5);
        chk("ld10_err", {31'b0, e}, 32'h0);
        chk("ld10_data", rdata, 32'hDEADBEEF);

        // Misaligned load
        do_op(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, lat, e, b1);
        chk("mis_lat", 32'(lat), 32'd2);
        chk("mis_err", {31'b0, e}, 32'h1);
        chk("mis_busy", {31'b0, b1}, 32'h0);
        chk("mis_rdata", rdata, 32'hDEADBEEF);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, e, b1);
        chk("mis_reld", rdata, 32'hDEADBEEF);

        // Out-of-range store (would alias word 0 if unchecked)
        do_op(1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0, lat, e, b1);
        chk("oor_lat", 32'(lat), 32'd2);
        chk("oor_err", {31'b0, e}, 32'h1);
        do_op(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, lat, e, b1);
        chk("oor_ld0", rdata, 32'hCAFEF00D);

        // Both strobes high
        do_op(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, lat, e, b1);
        chk("cfl_lat", 32'(lat), 32'd2);
        chk("cfl_err", {31'b0, e}, 32'h1);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, e, b1);
        chk("cfl_ld10", rdata, 32'hDEADBEEF);

        // Operands toggled during WAIT are ignored
        do_op(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, lat, e, b1);
        chk("tog_lat", 32'(lat), 32'd5);
        chk("tog_data", rdata, 32'hCAFEF00D);

        // Held request: two completions in ten cycles
        MemR = 1'b1;
        addr = 32'h10;
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        MemR = 1'b0;
        chk("held_pulses", 32'(pulses), 32'd2);
        chk("held_data", rdata, 32'hDEADBEEF);

        // Reset during WAIT of a store
        do_op(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, lat, e, b1);
        chk("st20_err", {31'b0, e}, 32'h0);
        MemW = 1'b1;
        addr = 32'h20;
        wdata = 32'h99999999;
        @(posedge clk);
        #1;
        chk("rm_busy_wait", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rm_busy", {31'b0, busy}, 32'h0);
        chk("rm_done", {31'b0, done}, 32'h0);
        chk("rm_rdata", rdata, 32'h0);
        MemW = 1'b0;
        pulses = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("rm_nodone", 32'(pulses), 32'd0);
        do_op(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, e, b1);
        chk("rm_lat", 32'(lat), 32'd5);
        chk("rm_ld20", rdata, 32'h11111111);

`ifdef DMEM_BYTE_STROBE_EN
        // Partial-byte store then zero-strobe store
        be = 4'b0101;
        do_op(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 1'b0, lat, e, b1);
        chk("be_err", {31'b0, e}, 32'h0);
        be = 4'hF;
        do_op(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, e, b1);
        chk("be_ld", rdata, 32'h11BB11DD);
        be = 4'b0000;
        do_op(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b0, lat, e, b1);
        chk("be0_lat", 32'(lat), 32'd5);
        chk("be0_err", {31'b0, e}, 32'h0);
        do_op(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, e, b1);
        chk("be0_ld", rdata, 32'h11BB11DD);
        be = 4'hF;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
